// File: rtl/cf_math_pkg.sv
// Shared math helpers used to size index and count fields.
package cf_math_pkg;

    function automatic integer idx_width(input integer num_idx);
        return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
    endfunction

endpackage

// File: rtl/dummy_pkg.sv
// Types and widths shared by the zero-count decoder and its bench.
package dummy_pkg;

    localparam int unsigned ERR_CNT_W  = 8;
    localparam int unsigned XFER_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FULL,
        ST_STALL
    } state_e;

endpackage

// File: rtl/lzc.sv
// Leading/trailing zero counter: MODE=0 counts from bit 0, MODE=1 from the MSB.
module lzc #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MODE      = 1'b0,
    parameter int unsigned CNT_WIDTH = cf_math_pkg::idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    always_comb begin
        cnt_o   = '0;
        empty_o = 1'b1;
        if (MODE == 1'b0) begin
            // Scan downwards so the lowest set bit is the last one written.
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (in_i[i]) begin
                    cnt_o   = CNT_WIDTH'(i);
                    empty_o = 1'b0;
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (in_i[i]) begin
                    cnt_o   = CNT_WIDTH'(WIDTH - 1 - i);
                    empty_o = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/dummy_lzc_decoder.sv
// Registered zero-count to one-hot decoder with handshake, lzc self-check
// and saturating error / transfer counters.
module dummy_lzc_decoder
    import dummy_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MODE      = 1'b0,
    parameter int unsigned CNT_WIDTH = cf_math_pkg::idx_width(WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [CNT_WIDTH-1:0]  cnt_i,
    input  logic                  empty_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [WIDTH-1:0]      data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  err_o,
    output logic [ERR_CNT_W-1:0]  err_cnt_o,
    output logic [XFER_CNT_W-1:0] xfer_cnt_o
);

    localparam int unsigned LZC_W = cf_math_pkg::idx_width(WIDTH);

    state_e state_q, state_d;

    logic [WIDTH-1:0]     data_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 empty_q;
    logic                 rerr_q;
    logic                 load_q;

    logic                 err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [XFER_CNT_W-1:0] xfer_cnt_q;

    logic                 in_xfer;
    logic                 rerr_in;
    logic [WIDTH-1:0]     dec;
    int                   pos;

    logic [LZC_W-1:0]     lzc_cnt;
    logic                 lzc_empty;
    logic                 mismatch;
    logic                 ev_range;
    logic                 ev_chk;
    logic [ERR_CNT_W:0]   err_sum;
    logic [ERR_CNT_W-1:0] err_cnt_d;
    logic [XFER_CNT_W-1:0] xfer_cnt_d;

    assign valid_o    = (state_q != ST_IDLE);
    assign ready_o    = rst_i || !valid_o || ready_i;
    assign in_xfer    = valid_i && ready_o && !rst_i;
    assign data_o     = data_q;
    assign err_o      = err_q;
    assign err_cnt_o  = err_cnt_q;
    assign xfer_cnt_o = xfer_cnt_q;

    always_comb begin
        dec     = '0;
        rerr_in = !empty_i && (32'(cnt_i) >= WIDTH);
        pos     = MODE ? (int'(WIDTH) - 1 - int'(32'(cnt_i))) : int'(32'(cnt_i));
        if (!empty_i && !rerr_in) begin
            for (int i = 0; i < WIDTH; i++) begin
                dec[i] = (i == pos);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_xfer) state_d = ST_FULL;
            end
            ST_FULL: begin
                if (!ready_i)     state_d = ST_STALL;
                else if (in_xfer) state_d = ST_FULL;
                else              state_d = ST_IDLE;
            end
            ST_STALL: begin
                if (ready_i) state_d = in_xfer ? ST_FULL : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    lzc #(
        .WIDTH (WIDTH),
        .MODE  (MODE)
    ) i_lzc (
        .in_i    (data_q),
        .cnt_o   (lzc_cnt),
        .empty_o (lzc_empty)
    );

    // Re-encode only the freshly loaded word; range-error loads are skipped.
    always_comb begin
        mismatch = (lzc_empty != empty_q)
                || (!empty_q && (32'(lzc_cnt) != 32'(cnt_q)));
        ev_chk   = load_q && valid_o && !rerr_q && mismatch;
        ev_range = in_xfer && rerr_in;
        err_sum  = {1'b0, err_cnt_q}
                 + (ERR_CNT_W+1)'(ev_chk) + (ERR_CNT_W+1)'(ev_range);
        err_cnt_d = err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
        xfer_cnt_d = xfer_cnt_q;
        if (in_xfer && (xfer_cnt_q != '1)) xfer_cnt_d = xfer_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            cnt_q      <= '0;
            empty_q    <= 1'b0;
            rerr_q     <= 1'b0;
            load_q     <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            xfer_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            load_q     <= in_xfer;
            err_cnt_q  <= err_cnt_d;
            xfer_cnt_q <= xfer_cnt_d;
            if (ev_chk || ev_range) err_q <= 1'b1;
            if (in_xfer) begin
                data_q  <= dec;
                cnt_q   <= cnt_i;
                empty_q <= empty_i;
                rerr_q  <= rerr_in;
            end
        end
    end

endmodule
